// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: burst command front end driving a single-port synchronous RAM.
module ram_burst_ctrl #(
  parameter int N          = 256,
  parameter int ADDR_WIDTH = $clog2(N),
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [31:0]           wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [31:0]           rd_data,
  output logic                  ram_read_write,
  output logic                  ram_enable,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_data_in,
  input  logic [31:0]           ram_data_out,
  output logic                  done
);
  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_WAIT, RD_HOLD, DONE} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_nxt;
  logic [LEN_WIDTH-1:0]  beats_q, beats_d;
  logic [31:0]           rd_data_q, rd_data_d;
  logic                  wr_hs, rd_hs, beat;
  assign rd_data = rd_data_q;
  // Every strobe is qualified by ~reset so a mid-burst reset stops RAM traffic in that very cycle.
  always_comb begin
    cmd_ready      = state_q == IDLE && !reset;
    wr_ready       = state_q == WR && !reset;
    rd_valid       = state_q == RD_HOLD && !reset;
    done           = state_q == DONE && !reset;
    wr_hs          = wr_ready && wr_valid;
    rd_hs          = rd_valid && rd_ready;
    beat           = wr_hs || rd_hs;
    ram_enable     = wr_hs || (state_q == RD_ISSUE && !reset);
    ram_read_write = wr_hs;
    ram_addr       = ram_enable ? addr_q : '0;
    ram_data_in    = wr_hs ? wr_data : '0;
    addr_nxt       = addr_q == ADDR_WIDTH'(N - 1) ? '0 : addr_q + 1'b1;
    state_d        = state_q;
    addr_d         = addr_q;
    beats_d        = beats_q;
    rd_data_d      = rd_data_q;
    if (cmd_ready && cmd_valid) begin
      state_d = cmd_write ? WR : RD_ISSUE;
      addr_d  = cmd_addr;
      beats_d = cmd_len;
    end
    if (state_q == RD_ISSUE) state_d = RD_WAIT;
    if (state_q == RD_WAIT) begin
      state_d   = RD_HOLD;
      rd_data_d = ram_data_out;
    end
    if (beat) begin
      addr_d  = addr_nxt;
      beats_d = beats_q == '0 ? beats_q : beats_q - 1'b1;
      state_d = beats_q == '0 ? DONE : (state_q == WR ? WR : RD_ISSUE);
    end
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      beats_q   <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      beats_q   <= beats_d;
      rd_data_q <= rd_data_d;
    end
  end
endmodule

// File: doc/ram_burst_ctrl.md
RAM_BURST_CTRL -- requirements
Module: ram_burst_ctrl

Interface
REQ-001 SHALL have parameter N, default 256, RAM depth in words.
REQ-002 SHALL have parameter ADDR_WIDTH, default $clog2(N), RAM address width.
REQ-003 SHALL have parameter LEN_WIDTH, default 4, burst length field width; bursts are 1..2^LEN_WIDTH beats.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port cmd_valid, input, 1, burst command offered.
REQ-007 SHALL have port cmd_ready, output, 1, controller accepts a command.
REQ-008 SHALL have port cmd_write, input, 1, 1 = write burst, 0 = read burst.
REQ-009 SHALL have port cmd_addr, input, ADDR_WIDTH, burst start address.
REQ-010 SHALL have port cmd_len, input, LEN_WIDTH, beat count minus 1.
REQ-011 SHALL have port wr_valid, input, 1, write beat offered.
REQ-012 SHALL have port wr_ready, output, 1, write beat accepted.
REQ-013 SHALL have port wr_data, input, 32, write beat data.
REQ-014 SHALL have port rd_valid, output, 1, read beat presented.
REQ-015 SHALL have port rd_ready, input, 1, read beat consumed.
REQ-016 SHALL have port rd_data, output, 32, registered read beat data.
REQ-017 SHALL have port ram_read_write, output, 1, to RAM read_write; 1 = write.
REQ-018 SHALL have port ram_enable, output, 1, to RAM enable.
REQ-019 SHALL have port ram_addr, output, ADDR_WIDTH, to RAM addr.
REQ-020 SHALL have port ram_data_in, output, 32, to RAM data_in.
REQ-021 SHALL have port ram_data_out, input, 32, from RAM data_out; valid the cycle after a read-enable cycle.
REQ-022 SHALL have port done, output, 1, one-cycle pulse at burst completion.

Function
REQ-023 SHALL implement states IDLE, WR, RD_ISSUE, RD_WAIT, RD_HOLD, DONE.
REQ-024 SHALL assert cmd_ready only in IDLE with reset low; on cmd_valid&cmd_ready, latch addr and len, beats_left = cmd_len, go to WR (cmd_write=1) or RD_ISSUE (cmd_write=0).
REQ-025 SHALL, in WR, drive wr_ready=1; on wr_valid, same cycle, drive ram_enable=1, ram_read_write=1, ram_addr=current addr, ram_data_in=wr_data.
REQ-026 SHALL, in WR, hold all RAM strobes low while wr_valid=0 (stall indefinitely, no timeout).
REQ-027 SHALL, in RD_ISSUE, drive ram_enable=1, ram_read_write=0, ram_addr=current addr for exactly one cycle, then go to RD_WAIT.
REQ-028 SHALL, in RD_WAIT, capture ram_data_out into rd_data at end of cycle and go to RD_HOLD.
REQ-029 SHALL, in RD_HOLD, assert rd_valid with rd_data stable until rd_ready=1.
REQ-030 SHALL give read latency: command accept edge T -> RD_ISSUE cycle T+1 -> rd_valid high cycle T+3.
REQ-031 SHALL, on each completed beat (write handshake or read handshake), increment addr modulo N (N-1 wraps to 0) and: if beats_left=0 go to DONE, else decrement beats_left and return to WR / RD_ISSUE.
REQ-032 SHALL, in DONE, assert done for one cycle and return to IDLE; cmd_ready low during DONE.
REQ-033 SHALL drive ram_enable=0, wr_ready=0, rd_valid=0 in IDLE and DONE.
REQ-034 SHALL ignore wr_valid outside WR and rd_ready outside RD_HOLD.
REQ-035 SHALL never issue more than one RAM access per cycle nor overlap a write and read burst.

Reset
REQ-036 SHALL, on a clk edge with reset=1, set state IDLE, addr 0, beats_left 0, rd_data 0.
REQ-037 SHALL gate cmd_ready, wr_ready, ram_enable, rd_valid, done low in any cycle where reset=1, including mid-burst.
REQ-038 SHALL abandon an in-progress burst on reset with no further RAM access; ram_read_write, ram_addr, ram_data_in read 0 in reset.

Verification
REQ-039 Write burst addr=0x00, len=3, data A5A5A5A5..A5A5A5A8 with wr_valid always high -> four consecutive write-enable cycles addr 0..3, done pulse next cycle.
REQ-040 Read burst addr=0x00, len=3 after REQ-039 -> rd_data A5A5A5A5..A5A5A5A8 in order; first rd_valid 3 cycles after accept.
REQ-041 Read burst with rd_ready low 5 cycles per beat -> rd_data held stable, no ram_enable during hold, no extra RAM reads.
REQ-042 Write burst addr=0xFE, len=3 -> writes at 0xFE, 0xFF, 0x00, 0x01; read-back matches.
REQ-043 Write burst with wr_valid toggling 1,0,0,1,... -> ram_enable only on wr_valid cycles; beat count exact.
REQ-044 Assert reset during beat 2 of a len=7 write -> no ram_enable after reset edge; cmd_ready high first cycle after reset deasserts; memory beyond beat 1 unchanged.
